usb_tx_scheduler: RTL and testbench

- Packet scheduler in front of the write port of the USB TX FIFO, which drains to the FT232H.
- Shares that single byte-wide write port between NUM_REQ requesters (image line stream, command responses, status) using round-robin arbitration.
- Frames every granted transfer as SYNC, channel id, length high, length low, payload, then an 8-bit checksum.
- Throttles on FIFO free space so that no byte is dropped by the FIFO's overflow checking.

---
 rtl/usb_tx_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/usb_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet scheduler.
// Packets are SYNC, channel, length (big-endian), payload, 8-bit checksum.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int unsigned HDR_BYTES         = 4;
    localparam int unsigned CSUM_BYTES        = 1;
    localparam int unsigned LEN_W             = 16;
    localparam int unsigned BYTE_W            = 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef struct packed {
        logic [BYTE_W-1:0] sync;
        logic [BYTE_W-1:0] chan;
        logic [LEN_W-1:0]  len;
    } pkt_hdr_t;

    // Header bytes leave in wire order: sync, channel, len high, len low.
    function automatic logic [BYTE_W-1:0] hdr_byte(input pkt_hdr_t hdr, input logic [1:0] idx);
        case (idx)
            2'd0:    return hdr.sync;
            2'd1:    return hdr.chan;
            2'd2:    return hdr.len[15:8];
            default: return hdr.len[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;

    // Rotate so bit 0 is the requester at ptr_i.
    assign w_rot = NUM_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        w_found = 1'b0;
        idx_o   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!w_found && w_rot[off]) begin
                w_found = 1'b1;
                idx_o   = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
            end
        end
        grant_o = w_found ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Round-robin packet scheduler feeding the byte-wide USB TX FIFO write port.
// Frames each grant as header, payload, checksum and throttles on FIFO space.
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TX_FIFO_DEPTH  = 512,
    parameter int unsigned TX_FIFO_WIDTHU = 9,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic                      clk_i,
    input  logic                      nrst,
    input  logic                      enable_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*LEN_W-1:0]  len_i,
    output logic [NUM_REQ-1:0]        grant_o,
    input  logic [NUM_REQ-1:0]        tvalid_i,
    input  logic [NUM_REQ*BYTE_W-1:0] tdata_i,
    output logic [NUM_REQ-1:0]        tready_o,
    output logic                      fifo_wrreq_o,
    output logic [BYTE_W-1:0]         fifo_wrdata_o,
    input  logic [TX_FIFO_WIDTHU-1:0] fifo_wrusedw_i,
    input  logic                      fifo_wrfull_i,
    output logic                      busy_o,
    output logic                      pkt_done_o
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HIDX_W = $clog2(HDR_BYTES);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]    r_gidx;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [LEN_W-1:0]    r_remaining;
    logic [BYTE_W-1:0]   r_csum;
    logic [HIDX_W-1:0]   r_hdr_idx;
    logic                r_wrreq;
    logic [BYTE_W-1:0]   r_wrdata;
    logic                r_busy;
    logic                r_pkt_done;

    logic [31:0]         w_free;
    logic                w_space_ok;
    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic [LEN_W-1:0]    w_req_len;
    logic [BYTE_W-1:0]   w_tdata;
    logic                w_tvalid;
    logic                w_hs;
    pkt_hdr_t            w_hdr;
    logic [IDX_W-1:0]    w_next_ptr;

    // Margin of two absorbs the one-cycle latency of the registered write.
    assign w_free     = fifo_wrfull_i ? 32'd0 : (32'(TX_FIFO_DEPTH) - 32'(fifo_wrusedw_i));
    assign w_space_ok = (w_free >= 32'd2);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (r_rr_ptr),
        .grant_o (w_arb_grant),
        .idx_o   (w_arb_idx)
    );

    always_comb begin
        w_req_len = '0;
        w_tdata   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) w_req_len = len_i[LEN_W*i +: LEN_W];
            if (r_grant[i])     w_tdata   = tdata_i[BYTE_W*i +: BYTE_W];
        end
    end

    assign w_tvalid   = |(tvalid_i & r_grant);
    assign w_hs       = (r_state == PAY) && w_space_ok && w_tvalid;
    assign w_hdr      = '{sync: SYNC_BYTE, chan: BYTE_W'(r_gidx), len: r_remaining};
    assign w_next_ptr = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : (r_gidx + IDX_W'(1));

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= '0;
            r_remaining <= '0;
            r_csum      <= '0;
            r_hdr_idx   <= '0;
            r_wrreq     <= 1'b0;
            r_wrdata    <= '0;
            r_busy      <= 1'b0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_wrreq    <= 1'b0;
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i && |req_i) begin
                        r_grant     <= w_arb_grant;
                        r_gidx      <= w_arb_idx;
                        r_remaining <= w_req_len;
                        r_csum      <= '0;
                        r_hdr_idx   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= HDR;
                    end
                end
                HDR: begin
                    if (w_space_ok) begin
                        r_wrreq   <= 1'b1;
                        r_wrdata  <= hdr_byte(w_hdr, 2'(r_hdr_idx));
                        r_hdr_idx <= r_hdr_idx + HIDX_W'(1);
                        if (r_hdr_idx == HIDX_W'(HDR_BYTES - 1)) begin
                            r_state <= (r_remaining != '0) ? PAY : CSUM;
                        end
                    end
                end
                PAY: begin
                    if (w_hs) begin
                        r_wrreq     <= 1'b1;
                        r_wrdata    <= w_tdata;
                        r_csum      <= r_csum + w_tdata;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) r_state <= CSUM;
                    end
                end
                CSUM: begin
                    if (w_space_ok) begin
                        r_wrreq    <= 1'b1;
                        r_wrdata   <= r_csum;
                        r_pkt_done <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = r_grant;
    assign tready_o      = ((r_state == PAY) && w_space_ok) ? r_grant : '0;
    assign fifo_wrreq_o  = r_wrreq;
    assign fifo_wrdata_o = r_wrdata;
    assign busy_o        = r_busy;
    assign pkt_done_o    = r_pkt_done;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler: scoreboarded FIFO byte stream,
// table-driven single packets plus fairness, backpressure, enable and reset sequences.
module tb_usb_tx_scheduler;

    logic        clk_i = 1'b0;
    logic        nrst;
    logic        enable_i;
    logic [1:0]  req_i;
    logic [31:0] len_i;
    logic [1:0]  grant_o;
    logic [1:0]  tvalid_i;
    logic [15:0] tdata_i;
    logic [1:0]  tready_o;
    logic        fifo_wrreq_o;
    logic [7:0]  fifo_wrdata_o;
    logic [8:0]  fifo_wrusedw_i;
    logic        fifo_wrfull_i;
    logic        busy_o;
    logic        pkt_done_o;

    always #5 clk_i = ~clk_i;

    usb_tx_scheduler #(
        .NUM_REQ        (2),
        .TX_FIFO_DEPTH  (512),
        .TX_FIFO_WIDTHU (9),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk_i          (clk_i),
        .nrst           (nrst),
        .enable_i       (enable_i),
        .req_i          (req_i),
        .len_i          (len_i),
        .grant_o        (grant_o),
        .tvalid_i       (tvalid_i),
        .tdata_i        (tdata_i),
        .tready_o       (tready_o),
        .fifo_wrreq_o   (fifo_wrreq_o),
        .fifo_wrdata_o  (fifo_wrdata_o),
        .fifo_wrusedw_i (fifo_wrusedw_i),
        .fifo_wrfull_i  (fifo_wrfull_i),
        .busy_o         (busy_o),
        .pkt_done_o     (pkt_done_o)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q0[$];
    logic [7:0] src_q1[$];
    logic [1:0] grant_log[$];
    logic [1:0] prev_grant = '0;
    logic [7:0] mon_exp;
    logic [7:0] dummy;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         hs_cnt = 0;
    int         tready_cnt = 0;
    logic       stall_mode = 1'b0;
    logic       phase = 1'b0;
    logic [1:0] hs_mask;

    typedef struct {
        int         idx;
        int         len;
        logic [7:0] start;
        logic [7:0] step;
        int         usedw;
        bit         stall;
        logic [7:0] csum;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_grant(input string name, input int exp);
        if (grant_log.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no grant expected 0x%0h", name, exp);
        end else begin
            check(name, int'(grant_log.pop_front()), exp);
        end
    endtask

    // FIFO-side scoreboard and event counters.
    always @(negedge clk_i) begin
        if (fifo_wrreq_o) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%02h expected nothing", fifo_wrdata_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_byte", int'(fifo_wrdata_o), int'(mon_exp));
            end
        end
        if (pkt_done_o) done_cnt++;
        if (|tready_o) tready_cnt++;
        if (grant_o != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant_o);
        prev_grant = grant_o;
    end

    // Payload sources: one queue per requester, optional 1010 tvalid pattern.
    initial begin
        tvalid_i = '0;
        tdata_i  = '0;
        forever begin
            @(negedge clk_i);
            hs_mask = tvalid_i & tready_o;
            @(posedge clk_i);
            #1;
            if (hs_mask[0] && src_q0.size() > 0) begin dummy = src_q0.pop_front(); hs_cnt++; end
            if (hs_mask[1] && src_q1.size() > 0) begin dummy = src_q1.pop_front(); hs_cnt++; end
            phase = ~phase;
            if (src_q0.size() > 0 && (!stall_mode || phase)) begin
                tvalid_i[0]  = 1'b1;
                tdata_i[7:0] = src_q0[0];
            end else tvalid_i[0] = 1'b0;
            if (src_q1.size() > 0 && (!stall_mode || phase)) begin
                tvalid_i[1]   = 1'b1;
                tdata_i[15:8] = src_q1[0];
            end else tvalid_i[1] = 1'b0;
        end
    end

    task automatic push_frame(input int idx, input int len, input logic [7:0] start,
                              input logic [7:0] step, input logic [7:0] csum);
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(idx));
        exp_q.push_back(8'(len >> 8));
        exp_q.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = 8'(int'(start) + k * int'(step));
            exp_q.push_back(b);
            if (idx == 0) src_q0.push_back(b);
            else          src_q1.push_back(b);
        end
        exp_q.push_back(csum);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int t = 0;
        while (!busy_o && t < 50) begin @(posedge clk_i); #1; t++; end
        if (!busy_o) begin
            n_vec++; n_err++;
            $display("FAIL %s_start_timeout: got busy=0 expected busy=1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy_o && t < 3000) begin @(posedge clk_i); #1; t++; end
        if (busy_o) begin
            n_vec++; n_err++;
            $display("FAIL %s_end_timeout: got busy=1 expected busy=0", name);
        end
        wait_cycles(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_done, b_hs, b_tr, t;
        vecs[0] = '{0, 3,   8'h01, 8'h01, 0,   1'b0, 8'h06};
        vecs[1] = '{1, 0,   8'h00, 8'h00, 0,   1'b0, 8'h00};
        vecs[2] = '{1, 4,   8'h80, 8'h40, 510, 1'b0, 8'h80};
        vecs[3] = '{0, 4,   8'h11, 8'h22, 0,   1'b1, 8'h10};
        vecs[4] = '{0, 5,   8'hFF, 8'h01, 0,   1'b0, 8'h05};
        vecs[5] = '{1, 2,   8'hF0, 8'h10, 0,   1'b0, 8'hF0};
        vecs[6] = '{0, 256, 8'h00, 8'h01, 0,   1'b0, 8'h80};

        nrst = 1'b0; enable_i = 1'b1; req_i = '0; len_i = '0;
        fifo_wrusedw_i = '0; fifo_wrfull_i = 1'b0;
        #1;
        check("rst_grant", int'(grant_o), 0);
        check("rst_tready", int'(tready_o), 0);
        check("rst_wrreq", int'(fifo_wrreq_o), 0);
        check("rst_wrdata", int'(fifo_wrdata_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(pkt_done_o), 0);
        wait_cycles(3);
        @(negedge clk_i); nrst = 1'b1;
        wait_cycles(2);

        // Fairness: both requesting, grants alternate starting from index 0.
        push_frame(0, 1, 8'h10, 8'h00, 8'h10);
        push_frame(1, 1, 8'h30, 8'h00, 8'h30);
        push_frame(0, 1, 8'h20, 8'h00, 8'h20);
        push_frame(1, 1, 8'h40, 8'h00, 8'h40);
        b_done = done_cnt;
        len_i = {16'd1, 16'd1};
        req_i = 2'b11;
        t = 0;
        while (grant_log.size() < 4 && t < 200) begin @(posedge clk_i); #1; t++; end
        req_i = 2'b00;
        wait_idle("fair");
        check_grant("fair_g0", 1);
        check_grant("fair_g1", 2);
        check_grant("fair_g2", 1);
        check_grant("fair_g3", 2);
        check("fair_done", done_cnt - b_done, 4);
        check("fair_left", exp_q.size(), 0);

        // Table-driven single-requester packets.
        for (int i = 0; i < 7; i++) begin
            fifo_wrusedw_i = 9'(vecs[i].usedw);
            stall_mode = vecs[i].stall;
            push_frame(vecs[i].idx, vecs[i].len, vecs[i].start, vecs[i].step, vecs[i].csum);
            b_wr = wr_cnt; b_done = done_cnt; b_hs = hs_cnt; b_tr = tready_cnt;
            if (vecs[i].idx == 0) len_i = {16'hFFFF, 16'(vecs[i].len)};
            else                  len_i = {16'(vecs[i].len), 16'hFFFF};
            req_i = 2'(1 << vecs[i].idx);
            wait_busy("vec");
            req_i = 2'b00;
            len_i = 32'h1234_5678;
            wait_idle("vec");
            check_grant("vec_grant", 1 << vecs[i].idx);
            check("vec_done", done_cnt - b_done, 1);
            check("vec_bytes", wr_cnt - b_wr, vecs[i].len + 5);
            check("vec_handshakes", hs_cnt - b_hs, vecs[i].len);
            if (vecs[i].len == 0) check("vec_tready_zero", tready_cnt - b_tr, 0);
            check("vec_left", exp_q.size(), 0);
        end
        stall_mode = 1'b0;
        fifo_wrusedw_i = '0;

        // Backpressure: free=1 and full both hold the header, then resume.
        push_frame(1, 2, 8'h3C, 8'h01, 8'h79);
        b_wr = wr_cnt; b_done = done_cnt;
        fifo_wrusedw_i = 9'd511;
        len_i = {16'd2, 16'd0};
        req_i = 2'b10;
        wait_busy("bp");
        req_i = 2'b00;
        wait_cycles(10);
        check("bp_hold_bytes", wr_cnt - b_wr, 0);
        check("bp_hold_busy", int'(busy_o), 1);
        fifo_wrusedw_i = 9'd0;
        fifo_wrfull_i = 1'b1;
        wait_cycles(5);
        check("full_hold_bytes", wr_cnt - b_wr, 0);
        fifo_wrfull_i = 1'b0;
        fifo_wrusedw_i = 9'd500;
        wait_idle("bp");
        check_grant("bp_grant", 2);
        check("bp_bytes", wr_cnt - b_wr, 7);
        check("bp_done", done_cnt - b_done, 1);
        check("bp_left", exp_q.size(), 0);
        fifo_wrusedw_i = '0;

        // Enable dropped mid-packet: packet finishes, no new one starts.
        push_frame(0, 2, 8'hA0, 8'h01, 8'h41);
        b_wr = wr_cnt;
        len_i = {16'd0, 16'd2};
        req_i = 2'b01;
        wait_busy("en");
        enable_i = 1'b0;
        wait_idle("en");
        wait_cycles(20);
        check_grant("en_grant", 1);
        check("en_no_restart", grant_log.size(), 0);
        check("en_bytes", wr_cnt - b_wr, 7);
        req_i = 2'b00;
        enable_i = 1'b1;

        // Reset mid-payload after two handshakes.
        push_frame(0, 10, 8'h50, 8'h01, 8'h4D);
        b_hs = hs_cnt;
        len_i = {16'd0, 16'd10};
        req_i = 2'b01;
        wait_busy("rst");
        req_i = 2'b00;
        t = 0;
        while (hs_cnt - b_hs < 2 && t < 100) begin @(posedge clk_i); #2; t++; end
        nrst = 1'b0;
        #1;
        check("midrst_grant", int'(grant_o), 0);
        check("midrst_tready", int'(tready_o), 0);
        check("midrst_wrreq", int'(fifo_wrreq_o), 0);
        check("midrst_wrdata", int'(fifo_wrdata_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_done", int'(pkt_done_o), 0);
        check("midrst_partial", exp_q.size(), 10);
        check_grant("midrst_pkt_grant", 1);
        exp_q.delete();
        src_q0.delete();
        wait_cycles(3);
        @(negedge clk_i); nrst = 1'b1;
        wait_cycles(2);

        // After reset the pointer is back at 0.
        push_frame(0, 0, 8'h00, 8'h00, 8'h00);
        b_done = done_cnt;
        len_i = '0;
        req_i = 2'b11;
        wait_busy("post");
        req_i = 2'b00;
        wait_idle("post");
        check_grant("post_grant", 1);
        check("post_done", done_cnt - b_done, 1);
        check("post_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
